// File: rtl/tpu_seq.sv
// Sequencer for a DIM x DIM systolic MAC array: CLEAR -> COMPUTE -> READ -> DONE.
// Optional busy-cycle counter on perf_cycles when TPU_SEQ_PERF_EN is defined.
module tpu_seq #(
  parameter int DIM   = 8,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clr_c,
  input  logic                   stall,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   mac_en,
  output logic                   mac_wren,
  output logic [$clog2(DIM)-1:0] cin_row,
  output logic                   ab_rd_en,
  output logic [IDX_W-1:0]       ab_idx,
  output logic                   c_rd_valid,
  output logic [$clog2(DIM)-1:0] c_rd_row,
  output logic [15:0]            perf_cycles
);

  localparam int RW = $clog2(DIM);
  localparam logic [IDX_W-1:0] RowLast = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] CmpLast = IDX_W'(3 * DIM - 3);
  localparam logic [IDX_W-1:0] AbLim   = IDX_W'(DIM);
  localparam logic [IDX_W-1:0] CntOne  = IDX_W'(1);

  typedef enum logic [2:0] {StIdle, StClear, StCompute, StRead, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             frz;
  logic [RW-1:0]    row_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frz     = 1'b0;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = clr_c ? StClear : StCompute;
            cnt_d   = '0;
          end
        end
        StClear: begin
          if (stall) begin
            frz = 1'b1;
          end else if (cnt_q == RowLast) begin
            state_d = StCompute;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StCompute: begin
          if (stall) begin
            frz = 1'b1;
          end else if (cnt_q == CmpLast) begin
            state_d = StRead;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StRead: begin
          if (stall) begin
            frz = 1'b1;
          end else if (cnt_q == RowLast) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StDone: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign row_d = cnt_d[RW-1:0];

  // Outputs are decoded from the next state so they line up with state_q without comb paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mac_en     <= 1'b0;
      mac_wren   <= 1'b0;
      cin_row    <= '0;
      ab_rd_en   <= 1'b0;
      ab_idx     <= '0;
      c_rd_valid <= 1'b0;
      c_rd_row   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy       <= (state_d == StClear) || (state_d == StCompute) || (state_d == StRead);
      done       <= (state_d == StDone);
      mac_en     <= ((state_d == StClear) || (state_d == StCompute)) && !frz;
      mac_wren   <= (state_d == StClear) && !frz;
      cin_row    <= (state_d == StClear) ? row_d : '0;
      ab_rd_en   <= (state_d == StCompute) && (cnt_d < AbLim) && !frz;
      ab_idx     <= (state_d == StCompute) ? cnt_d : '0;
      c_rd_valid <= (state_d == StRead) && !frz;
      c_rd_row   <= (state_d == StRead) ? row_d : '0;
    end
  end

`ifdef TPU_SEQ_PERF_EN
  logic [15:0] perf_cnt_q;
  logic [15:0] perf_inc;

  assign perf_inc = (perf_cnt_q == 16'hFFFF) ? perf_cnt_q : perf_cnt_q + 16'd1;

  // busy is high for exactly the busy cycles, so the last READ cycle publishes the total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q  <= '0;
      perf_cycles <= '0;
    end else if ((state_q == StIdle) && start) begin
      perf_cnt_q <= '0;
    end else if (busy) begin
      perf_cnt_q <= perf_inc;
      if (state_d == StDone) begin
        perf_cycles <= perf_inc;
      end
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_tpu_seq.sv
// Scoreboard bench for tpu_seq (DIM=4): expected output events are queued from an abstract
// step list of the pass; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_tpu_seq;

  localparam int DIM   = 4;
  localparam int IDX_W = 4;

  typedef struct packed {
    logic       mac_en;
    logic       mac_wren;
    logic [1:0] cin_row;
    logic       ab_rd_en;
    logic [3:0] ab_idx;
    logic       c_rd_valid;
    logic [1:0] c_rd_row;
    logic       done;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, clr_c = 1'b0, stall = 1'b0, abort = 1'b0;
  logic        busy, done, mac_en, mac_wren, ab_rd_en, c_rd_valid;
  logic [1:0]  cin_row, c_rd_row;
  logic [3:0]  ab_idx;
  logic [15:0] perf_cycles;

  tpu_seq #(.DIM(DIM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_c(clr_c), .stall(stall), .abort(abort),
    .busy(busy), .done(done), .mac_en(mac_en), .mac_wren(mac_wren), .cin_row(cin_row),
    .ab_rd_en(ab_rd_en), .ab_idx(ab_idx), .c_rd_valid(c_rd_valid), .c_rd_row(c_rd_row),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  rec_t sb[$];
  rec_t steps[$];
  int   p = 0;
  bit   in_pass = 0;
  bit   stall_cur = 0;
  int   busy_cnt = 0;
  int   perf_cur = 0;
  bit   smp_done = 0;
  int   lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_perf();
`ifdef TPU_SEQ_PERF_EN
    return 32'(perf_cur);
`else
    return 32'd0;
`endif
  endfunction

  // Whole pass as a flat list of what each non-stalled cycle shows, ending with the done cycle.
  task automatic build(input bit clr);
    rec_t r;
    steps.delete();
    if (clr)
      for (int i = 0; i < DIM; i++) begin
        r = '0; r.mac_en = 1; r.mac_wren = 1; r.cin_row = 2'(i); steps.push_back(r);
      end
    for (int i = 0; i < 3 * DIM - 2; i++) begin
      r = '0; r.mac_en = 1; r.ab_rd_en = (i < DIM); r.ab_idx = 4'(i); steps.push_back(r);
    end
    for (int i = 0; i < DIM; i++) begin
      r = '0; r.c_rd_valid = 1; r.c_rd_row = 2'(i); steps.push_back(r);
    end
    r = '0; r.done = 1; steps.push_back(r);
  endtask

  // Monitor: every cycle with visible activity must match the oldest queued expectation.
  always @(negedge clk) begin
    rec_t act, exp;
    if (rst_n && (mac_en || c_rd_valid || done)) begin
      act = {mac_en, mac_wren, cin_row, ab_rd_en, ab_idx, c_rd_valid, c_rd_row, done};
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL event_unexpected actual=%0h expected=none at %0t", act, $time);
      end else begin
        exp = sb.pop_front();
        chk("event", 32'(act), 32'(exp));
      end
    end
  end

  task automatic cycle(input bit st, input bit cl, input bit sl, input bit ab);
    bit exp_busy, exp_done;
    @(negedge clk);
    smp_done = done;
    exp_busy = 0;
    exp_done = 0;
    if (in_pass) begin
      exp_busy = !steps[p].done;
      exp_done = steps[p].done;
    end
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("perf_cycles", 32'(perf_cycles), exp_perf());
    if (stall_cur)
      chk("stall_hold", {18'd0, mac_en, mac_wren, ab_rd_en, c_rd_valid, cin_row, ab_idx, c_rd_row},
          {18'd0, 4'b0000, steps[p].cin_row, steps[p].ab_idx, steps[p].c_rd_row});
    start = st; clr_c = cl; stall = sl; abort = ab;
    stall_cur = 0;
    if (in_pass) begin
      if (ab || steps[p].done) begin
        in_pass = 0;
      end else if (sl) begin
        stall_cur = 1;
        busy_cnt++;
      end else begin
        p++;
        if (steps[p].done) perf_cur = (busy_cnt > 65535) ? 65535 : busy_cnt;
        else busy_cnt++;
        sb.push_back(steps[p]);
      end
    end else if (st) begin
      build(cl);
      p = 0;
      in_pass = 1;
      busy_cnt = 1;
      sb.push_back(steps[0]);
    end
  endtask

  task automatic pass_run(input bit clr, input int stall_p, input int stall_len,
                          input int abort_p, input int start_p, output int first_done);
    int nst;
    bit sl, ab, st;
    nst = 0;
    first_done = 0;
    cycle(1, clr, 0, 0);
    for (int i = 1; i <= 25; i++) begin
      sl = 0; ab = 0; st = 0;
      if (in_pass && p == stall_p && nst < stall_len) begin sl = 1; nst++; end
      if (in_pass && p == abort_p) ab = 1;
      if (in_pass && p == start_p) st = 1;
      cycle(st, 0, sl, ab);
      if (smp_done && first_done == 0) first_done = i;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {9'd0, busy, done, mac_en, mac_wren, cin_row, ab_rd_en, ab_idx,
        c_rd_valid, c_rd_row, perf_cycles}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1;

    pass_run(0, -1, 0, -1, -1, lat);
    chk("latency_noclr", 32'(lat), 32'd15);
`ifdef TPU_SEQ_PERF_EN
    chk("perf_noclr", 32'(perf_cycles), 32'd14);
`endif
    pass_run(1, -1, 0, -1, -1, lat);
    chk("latency_clr", 32'(lat), 32'd19);
`ifdef TPU_SEQ_PERF_EN
    chk("perf_clr", 32'(perf_cycles), 32'd18);
`endif
    pass_run(0, 2, 3, -1, -1, lat);
    chk("latency_stall", 32'(lat), 32'd18);
`ifdef TPU_SEQ_PERF_EN
    chk("perf_stall", 32'(perf_cycles), 32'd17);
`endif
    pass_run(0, -1, 0, 11, 3, lat);
    chk("abort_no_done", 32'(lat), 32'd0);
`ifdef TPU_SEQ_PERF_EN
    chk("perf_after_abort", 32'(perf_cycles), 32'd17);
`endif

    // Asynchronous reset while ab_idx shows 5.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10 && p != 5; i++) cycle(0, 0, 0, 0);
    @(posedge clk);
    #1 chk("pre_reset_idx", 32'(ab_idx), 32'd5);
    #1 rst_n = 0;
    #1 chk("reset_mid_compute", {9'd0, busy, done, mac_en, mac_wren, cin_row, ab_rd_en, ab_idx,
           c_rd_valid, c_rd_row, perf_cycles}, 32'd0);
    sb.delete();
    in_pass = 0; stall_cur = 0; perf_cur = 0;
    @(posedge clk);
    #2 rst_n = 1;
    repeat (3) cycle(0, 0, 1, 1);

    for (int i = 0; i < 2000; i++)
      cycle(in_pass ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);

    repeat (25) cycle(0, 0, 0, 0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
